// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline definitions: widths, reset PC, opcode class codes
// and the top-bit match patterns used by the front-end pre-decoder.
package cpu_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [63:0] RESET_PC = 64'd0;

  typedef enum logic [3:0] {
    OP_PC_INIT = 4'd0,
    OP_ADDI    = 4'd1,
    OP_ADDS    = 4'd2,
    OP_BLT     = 4'd3,
    OP_B       = 4'd4,
    OP_CBZ     = 4'd5,
    OP_LDUR    = 4'd6,
    OP_LSL     = 4'd7,
    OP_LSR     = 4'd8,
    OP_MUL     = 4'd9,
    OP_STUR    = 4'd10,
    OP_SUBS    = 4'd11,
    OP_INV     = 4'd12
  } opclass_t;

  localparam logic [5:0]  PAT_B        = 6'b000101;
  localparam logic [7:0]  PAT_BLT      = 8'b01010100;
  localparam logic [4:0]  PAT_BLT_COND = 5'b01011;
  localparam logic [7:0]  PAT_CBZ      = 8'b10110100;
  localparam logic [9:0]  PAT_ADDI     = 10'b1001000100;
  localparam logic [10:0] PAT_ADDS     = 11'b10101011000;
  localparam logic [10:0] PAT_SUBS     = 11'b11101011000;
  localparam logic [10:0] PAT_LDUR     = 11'b11111000010;
  localparam logic [10:0] PAT_STUR     = 11'b11111000000;
  localparam logic [10:0] PAT_LSL      = 11'b11010011011;
  localparam logic [10:0] PAT_LSR      = 11'b11010011010;
  localparam logic [10:0] PAT_MUL      = 11'b10011011000;

endpackage

// File: rtl/add.sv
// Plain W-bit adder; the carry out is discarded so sums wrap modulo 2^W.
module add #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/opcode_dec.sv
// Maps an RF-stage instruction word to its 4-bit opcode class.
// Patterns are tried in a fixed order; an empty slot always decodes as INV.
module opcode_dec
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        valid,
  output logic [3:0]  opcode
);

  // Operand fields play no part in classification.
  logic unused_fields;
  assign unused_fields = ^instr[20:5];

  // Priority match of the leading opcode bits
  always_comb begin
    opcode = OP_INV;
    if (!valid) begin
      opcode = OP_INV;
    end else if (instr[31:26] == PAT_B) begin
      opcode = OP_B;
    end else if ((instr[31:24] == PAT_BLT) && (instr[4:0] == PAT_BLT_COND)) begin
      opcode = OP_BLT;
    end else if (instr[31:24] == PAT_CBZ) begin
      opcode = OP_CBZ;
    end else if (instr[31:22] == PAT_ADDI) begin
      opcode = OP_ADDI;
    end else if (instr[31:21] == PAT_ADDS) begin
      opcode = OP_ADDS;
    end else if (instr[31:21] == PAT_SUBS) begin
      opcode = OP_SUBS;
    end else if (instr[31:21] == PAT_LDUR) begin
      opcode = OP_LDUR;
    end else if (instr[31:21] == PAT_STUR) begin
      opcode = OP_STUR;
    end else if (instr[31:21] == PAT_LSL) begin
      opcode = OP_LSL;
    end else if (instr[31:21] == PAT_LSR) begin
      opcode = OP_LSR;
    end else if (instr[31:21] == PAT_MUL) begin
      opcode = OP_MUL;
    end else begin
      opcode = OP_INV;
    end
  end

endmodule

// File: rtl/se.sv
// Sign extender: replicates the top bit of a W-bit field up to OUT_W bits.
module se #(
  parameter int W     = 19,
  parameter int OUT_W = 64
) (
  input  logic [W-1:0]     din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W - W){din[W-1]}}, din};

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch with one-instruction branch delay slot and the
// IF/RF pipeline register, plus opcode-class and branch-immediate pre-decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    pc_br,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_rf,
  output logic [3:0]         opcode,
  output logic [PC_W-1:0]    imm19,
  output logic [PC_W-1:0]    imm26,
  output logic               valid_rf
);

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;

  add #(.W(PC_W)) u_pc_inc (
    .a   (pc),
    .b   (PC_STEP),
    .sum (pc_plus4)
  );

  // PC and IF/RF register; the word fetched alongside a taken branch is the
  // delay slot and is loaded normally, so there is no flush path.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= PC_RST;
      pc_out   <= {PC_W{1'b0}};
      instr_rf <= {INSTR_W{1'b0}};
      valid_rf <= 1'b0;
    end else if (stall) begin
      pc       <= pc;
      pc_out   <= pc_out;
      instr_rf <= instr_rf;
      valid_rf <= valid_rf;
    end else begin
      pc       <= br_taken ? pc_br : pc_plus4;
      pc_out   <= pc;
      instr_rf <= imem_data;
      valid_rf <= 1'b1;
    end
  end

  assign imem_addr = pc;

  opcode_dec u_dec (
    .instr  (instr_rf[31:0]),
    .valid  (valid_rf),
    .opcode (opcode)
  );

  se #(.W(19), .OUT_W(PC_W)) u_se19 (
    .din  (instr_rf[23:5]),
    .dout (imm19)
  );

  se #(.W(26), .OUT_W(PC_W)) u_se26 (
    .din  (instr_rf[25:0]),
    .dout (imm26)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reference model predicts each edge,
// predictions go through a scoreboard queue and are compared after the edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [63:0] pc_br, imem_addr, pc_out, imm19, imm26;
  logic [31:0] imem_data, instr_rf;
  logic [3:0]  opcode;
  logic        valid_rf;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [0:15];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  op;
    logic [63:0] i19;
    logic [63:0] i26;
  } exp_t;

  exp_t sb[$];

  logic [63:0] m_pc, m_pc_rf;
  logic [31:0] m_instr;
  logic        m_valid;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr[5:2]];

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_taken  (br_taken),
    .pc_br     (pc_br),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .pc_out    (pc_out),
    .instr_rf  (instr_rf),
    .opcode    (opcode),
    .imm19     (imm19),
    .imm26     (imm26),
    .valid_rf  (valid_rf)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [31:0] w, input logic v);
    if (!v)                                      return 4'd12;
    if ((w & 32'hFC000000) == 32'h14000000)      return 4'd4;
    if ((w & 32'hFF00001F) == 32'h5400000B)      return 4'd3;
    if ((w & 32'hFF000000) == 32'hB4000000)      return 4'd5;
    if ((w & 32'hFFC00000) == 32'h91000000)      return 4'd1;
    if ((w & 32'hFFE00000) == 32'hAB000000)      return 4'd2;
    if ((w & 32'hFFE00000) == 32'hEB000000)      return 4'd11;
    if ((w & 32'hFFE00000) == 32'hF8400000)      return 4'd6;
    if ((w & 32'hFFE00000) == 32'hF8000000)      return 4'd10;
    if ((w & 32'hFFE00000) == 32'hD3600000)      return 4'd7;
    if ((w & 32'hFFE00000) == 32'hD3400000)      return 4'd8;
    if ((w & 32'hFFE00000) == 32'h9B000000)      return 4'd9;
    return 4'd12;
  endfunction

  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] tgt);
    exp_t e;
    exp_t got;
    reset = r; stall = s; br_taken = b; pc_br = tgt;
    if (r) begin
      m_pc = 64'd0; m_pc_rf = 64'd0; m_instr = 32'd0; m_valid = 1'b0;
    end else if (!s) begin
      m_pc_rf = m_pc;
      m_instr = rom[m_pc[5:2]];
      m_valid = 1'b1;
      m_pc    = b ? tgt : m_pc + 64'd4;
    end
    e.addr  = m_pc;
    e.pc    = m_pc_rf;
    e.instr = m_instr;
    e.valid = m_valid;
    e.op    = ref_op(m_instr, m_valid);
    e.i19   = 64'($signed(m_instr[23:5]));
    e.i26   = 64'($signed(m_instr[25:0]));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check_eq("imem_addr", imem_addr, got.addr);
      check_eq("pc_out",    pc_out,    got.pc);
      check_eq("instr_rf",  {32'd0, instr_rf}, {32'd0, got.instr});
      check_eq("valid_rf",  {63'd0, valid_rf}, {63'd0, got.valid});
      check_eq("opcode",    {60'd0, opcode},   {60'd0, got.op});
      check_eq("imm19",     imm19, got.i19);
      check_eq("imm26",     imm26, got.i26);
    end
  endtask

  initial begin
    rom[0]  = 32'hB4FFFFE0; rom[1]  = 32'h14000003; rom[2]  = 32'h5400000B;
    rom[3]  = 32'hFFFFFFFF; rom[4]  = 32'h91000421; rom[5]  = 32'hAB020020;
    rom[6]  = 32'hEB030041; rom[7]  = 32'hF8400000; rom[8]  = 32'hF8000000;
    rom[9]  = 32'hD3600000; rom[10] = 32'hD3400000; rom[11] = 32'h9B000000;
    rom[12] = 32'h12345678; rom[13] = 32'h17FFFFFF; rom[14] = 32'h54000001;
    rom[15] = 32'hB4000020;
    m_pc = 64'd0; m_pc_rf = 64'd0; m_instr = 32'd0; m_valid = 1'b0;

    // reset, then sequential fetch with decode of the first words
    step(1'b1, 1'b0, 1'b0, 64'd0);
    step(1'b1, 1'b0, 1'b0, 64'd0);
    check_eq("rst_opcode_inv", {60'd0, opcode}, 64'd12);
    check_eq("rst_valid", {63'd0, valid_rf}, 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("first_valid", {63'd0, valid_rf}, 64'd1);
    check_eq("seq_addr4", imem_addr, 64'd4);
    check_eq("cbz_op", {60'd0, opcode}, 64'd5);
    check_eq("cbz_imm19", imm19, 64'hFFFF_FFFF_FFFF_FFFF);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("seq_addr8", imem_addr, 64'd8);
    check_eq("b_op", {60'd0, opcode}, 64'd4);
    check_eq("b_imm26", imm26, 64'd3);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("seq_addr12", imem_addr, 64'd12);
    check_eq("blt_op", {60'd0, opcode}, 64'd3);
    check_eq("br_in_rf_pc", pc_out, 64'd8);

    // taken branch at 8: delay slot 12 then target 20
    step(1'b0, 1'b0, 1'b1, 64'd20);
    check_eq("slot_pc", pc_out, 64'd12);
    check_eq("inv_op", {60'd0, opcode}, 64'd12);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("target_pc", pc_out, 64'd20);

    // stall for three cycles at PC 16
    step(1'b1, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'd0);
      check_eq("stall_addr", imem_addr, 64'd16);
      check_eq("stall_pc_out", pc_out, 64'd12);
    end
    step(1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("resume_addr", imem_addr, 64'd20);

    // stall beats branch, branch re-asserted next cycle
    step(1'b0, 1'b1, 1'b1, 64'd40);
    check_eq("stall_br_hold", imem_addr, 64'd20);
    step(1'b0, 1'b0, 1'b1, 64'd40);
    check_eq("br_after_stall", imem_addr, 64'd40);

    // PC wrap
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 64'd0);
    check_eq("wrap_addr", imem_addr, 64'd0);

    // random traffic through the scoreboard
    for (int i = 0; i < 60; i++) begin
      step(1'b0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           64'($urandom_range(0, 15)) << 2);
    end

    // reset overrides stall and branch
    step(1'b1, 1'b1, 1'b1, 64'd40);
    check_eq("midrst_addr", imem_addr, 64'd0);
    check_eq("midrst_valid", {63'd0, valid_rf}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
